// File: rtl/hbmc_pkg.sv
// Shared HyperBus controller definitions: sequencer states, CA length and RWDS mask encodings.
package hbmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_DATA,
    ST_DONE
  } hb_state_e;

  // Command/address phase length in clocks.
  localparam int unsigned CA_CLOCKS = 3;

  // RWDS during writes is a byte mask: 1 = byte masked (not written).
  localparam logic [1:0] RWDS_PREAMBLE   = 2'b00;
  localparam logic [1:0] RWDS_MASK_ALL   = 2'b11;

  // Byte strobes (1 = write byte) map to the inverted RWDS mask pair.
  function automatic logic [1:0] rwds_mask(input logic [1:0] strb);
    return ~strb;
  endfunction

endpackage

// File: rtl/hbmc_down_counter.sv
// Loadable down-counter; load takes priority over decrement, saturates at zero.
module hbmc_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  // Count register: reset to zero, load or decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/hb_rwds_wr_seq.sv
// HyperBus RWDS write sequencer: CA, latency, preamble and per-beat byte masks.
// RWDS pins are registered: what a state decides appears on the pins one clock later.
module hb_rwds_wr_seq
  import hbmc_pkg::*;
#(
  parameter int unsigned BURST_W     = 16,
  parameter int unsigned MIN_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_write,
  input  logic [3:0]         latency,
  input  logic               fixed_latency,
  input  logic [BURST_W-1:0] burst_words,
  input  logic               rwds_sample,
  input  logic [1:0]         wr_strb,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [1:0]         rwds_sdr,
  output logic               rwds_t,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  // Holds up to twice the largest 4-bit latency.
  localparam int unsigned LAT_W = 5;

  hb_state_e          state, state_d;
  logic               is_write_q, fixed_q, dbl_q;
  logic [3:0]         lat_q;
  logic               take_start, sample_dbl;
  logic               lat_load, lat_en, word_load, word_en;
  logic [LAT_W-1:0]   lat_val, lat_cnt, lat_base, leff;
  logic [BURST_W-1:0] word_val, word_cnt;
  logic               rwds_t_d, underrun_d;
  logic [1:0]         rwds_sdr_d;

  // The latency counter first times the CA phase, then is reloaded with Leff.
  hbmc_down_counter #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .en       (lat_en),
    .load_val (lat_val),
    .count    (lat_cnt)
  );

  hbmc_down_counter #(.W(BURST_W)) u_word_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (word_load),
    .en       (word_en),
    .load_val (word_val),
    .count    (word_cnt)
  );

  // Effective latency: clamp to the minimum, double when the device asks for it.
  always_comb begin
    lat_base = (LAT_W'(lat_q) < LAT_W'(MIN_LATENCY)) ? LAT_W'(MIN_LATENCY) : LAT_W'(lat_q);
    leff     = dbl_q ? (lat_base << 1) : lat_base;
  end

  assign word_val = (burst_words == '0) ? BURST_W'(1) : burst_words;
  assign wr_ready = (state == ST_DATA);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, counter control and next RWDS pin values.
  always_comb begin
    state_d    = state;
    take_start = 1'b0;
    sample_dbl = 1'b0;
    lat_load   = 1'b0;
    lat_en     = 1'b0;
    lat_val    = '0;
    word_load  = 1'b0;
    word_en    = 1'b0;
    rwds_t_d   = 1'b1;
    rwds_sdr_d = RWDS_PREAMBLE;
    underrun_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          lat_load   = 1'b1;
          lat_val    = LAT_W'(CA_CLOCKS);
          word_load  = 1'b1;
          state_d    = ST_CA;
        end
      end
      ST_CA: begin
        lat_en = 1'b1;
        if (lat_cnt == LAT_W'(CA_CLOCKS)) begin
          sample_dbl = 1'b1;
        end
        if (lat_cnt == LAT_W'(1)) begin
          if (is_write_q) begin
            lat_load = 1'b1;
            lat_val  = leff;
            state_d  = ST_LAT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LAT: begin
        lat_en = 1'b1;
        if (lat_cnt == LAT_W'(1)) begin
          rwds_t_d   = 1'b0;
          rwds_sdr_d = RWDS_PREAMBLE;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        word_en  = 1'b1;
        rwds_t_d = 1'b0;
        if (wr_valid) begin
          rwds_sdr_d = rwds_mask(wr_strb);
        end else begin
          rwds_sdr_d = RWDS_MASK_ALL;
          underrun_d = 1'b1;
        end
        if (word_cnt == BURST_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction context latched on start; latency doubling sampled on the first CA clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write_q <= 1'b0;
      fixed_q    <= 1'b0;
      lat_q      <= '0;
      dbl_q      <= 1'b0;
    end else begin
      if (take_start) begin
        is_write_q <= is_write;
        fixed_q    <= fixed_latency;
        lat_q      <= latency;
      end
      if (sample_dbl) begin
        dbl_q <= fixed_q | rwds_sample;
      end
    end
  end

  // Registered RWDS pin drive and underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rwds_t   <= 1'b1;
      rwds_sdr <= '0;
      underrun <= 1'b0;
    end else begin
      rwds_t   <= rwds_t_d;
      rwds_sdr <= rwds_sdr_d;
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_hb_rwds_wr_seq.sv
// Directed bench for hb_rwds_wr_seq with a scoreboard of expected RWDS beats.
module tb_hb_rwds_wr_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_write, fixed_latency, rwds_sample, wr_valid;
  logic [3:0]  latency;
  logic [15:0] burst_words;
  logic [1:0]  wr_strb;
  logic        wr_ready, rwds_t, busy, done, underrun;
  logic [1:0]  rwds_sdr;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {underrun, rwds_sdr} per write beat.
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  hb_rwds_wr_seq #(.BURST_W(16), .MIN_LATENCY(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .is_write      (is_write),
    .latency       (latency),
    .fixed_latency (fixed_latency),
    .burst_words   (burst_words),
    .rwds_sample   (rwds_sample),
    .wr_strb       (wr_strb),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rwds_sdr      (rwds_sdr),
    .rwds_t        (rwds_t),
    .busy          (busy),
    .done          (done),
    .underrun      (underrun)
  );

  task automatic chk(input string name, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", name, tag, obs, exp);
    end
  endtask

  // Called during an IDLE clock (just after a falling edge); returns during the next IDLE clock.
  task automatic run_txn(input string name, input logic wr, input logic [3:0] lat, input logic fx,
                         input logic rs, input logic [15:0] bw, input logic [15:0] strb_pat,
                         input logic [7:0] vmask, input int abort_beat, input logic hold);
    int base, leff, nbeats, n, bad_t;
    logic [2:0] e;
    logic [1:0] s;
    logic       v;
    base   = (lat < 4'd3) ? 3 : int'(lat);
    leff   = (fx | rs) ? 2 * base : base;
    nbeats = (bw == 16'd0) ? 1 : int'(bw);
    start = 1'b1; is_write = wr; latency = lat; fixed_latency = fx;
    burst_words = bw; rwds_sample = rs;
    @(negedge clk);
    chk(name, "ca_busy", busy, 1);
    if (!hold) start = 1'b0;
    n = 0; bad_t = 0;
    while (!(wr_ready === 1'b1 || done === 1'b1) && n < 64) begin
      if (rwds_t !== 1'b1) bad_t++;
      @(negedge clk);
      n++;
    end
    rwds_sample = 1'b0;
    chk(name, "clocks_before_data", n, wr ? 3 + leff : 3);
    chk(name, "rwds_t_high_ca_lat", bad_t, 0);
    if (!wr) begin
      chk(name, "read_done", done, 1);
      chk(name, "read_rwds_t", rwds_t, 1);
    end else begin
      chk(name, "preamble", {underrun, rwds_t, rwds_sdr}, 4'b0000);
      for (int i = 0; i < nbeats; i++) begin
        chk(name, "wr_ready", wr_ready, 1);
        s = (i < 8) ? strb_pat[2*i +: 2] : 2'b11;
        v = (i < 8) ? vmask[i] : 1'b1;
        wr_valid = v; wr_strb = s;
        exp_q.push_back(v ? {1'b0, ~s} : 3'b111);
        if (i == abort_beat) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0; wr_valid = 1'b0;
          exp_q.delete();
          chk(name, "abort_busy", busy, 0);
          chk(name, "abort_rwds_t", rwds_t, 1);
          chk(name, "abort_done", done, 0);
          @(negedge clk);
          chk(name, "abort_no_done", done, 0);
          chk(name, "abort_idle", busy, 0);
          return;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        chk(name, "beat_mask", {underrun, rwds_sdr}, e);
        chk(name, "beat_rwds_t", rwds_t, 0);
      end
      wr_valid = 1'b0;
      chk(name, "done_pulse", done, 1);
      chk(name, "done_not_ready", wr_ready, 0);
    end
    @(negedge clk);
    chk(name, "idle_busy", busy, 0);
    chk(name, "idle_done", done, 0);
    chk(name, "idle_rwds_t", rwds_t, 1);
    chk(name, "idle_underrun", underrun, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_write = 1'b0; fixed_latency = 1'b0; rwds_sample = 1'b0;
    wr_valid = 1'b0; latency = '0; burst_words = '0; wr_strb = '0;
    repeat (3) @(negedge clk);
    chk("reset", "outputs", {wr_ready, busy, done, underrun, rwds_t, rwds_sdr}, 7'b0000100);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "idle_after", busy, 0);

    run_txn("wr_l6",      1'b1, 4'd6, 1'b0, 1'b0, 16'd4, 16'hFFFF, 8'hFF, -1, 1'b0);
    run_txn("wr_rwds_dbl",1'b1, 4'd6, 1'b0, 1'b1, 16'd4, 16'hFFFF, 8'hFF, -1, 1'b0);
    run_txn("wr_fixed",   1'b1, 4'd6, 1'b1, 1'b0, 16'd4, 16'hFFFF, 8'hFF, -1, 1'b0);
    // strobes 01, 10, 00 packed beat0 in the low bits
    run_txn("wr_strobes", 1'b1, 4'd6, 1'b0, 1'b0, 16'd3, 16'b00_10_01, 8'hFF, -1, 1'b0);
    run_txn("wr_underrun",1'b1, 4'd6, 1'b0, 1'b0, 16'd4, 16'hFFFF, 8'b1111_1101, -1, 1'b0);
    run_txn("rd_l2",      1'b0, 4'd2, 1'b0, 1'b0, 16'd4, 16'hFFFF, 8'hFF, -1, 1'b0);
    run_txn("wr_l2_clamp",1'b1, 4'd2, 1'b0, 1'b0, 16'd2, 16'hFFFF, 8'hFF, -1, 1'b0);
    run_txn("wr_bw0",     1'b1, 4'd4, 1'b0, 1'b0, 16'd0, 16'hFFFF, 8'hFF, -1, 1'b0);
    run_txn("wr_abort",   1'b1, 4'd3, 1'b0, 1'b0, 16'd4, 16'hFFFF, 8'hFF, 1, 1'b0);
    run_txn("b2b_0",      1'b1, 4'd3, 1'b0, 1'b0, 16'd2, 16'b01_10, 8'hFF, -1, 1'b1);
    run_txn("b2b_1",      1'b0, 4'd5, 1'b0, 1'b0, 16'd1, 16'hFFFF, 8'hFF, -1, 1'b1);
    run_txn("b2b_2",      1'b1, 4'd4, 1'b0, 1'b1, 16'd3, 16'b00_11_01, 8'hFF, -1, 1'b0);

    repeat (2) @(negedge clk);
    chk("end", "idle", {busy, done, rwds_t}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
